// File: rtl/keypad_emulator_if.sv
// Command handshake bundle for the keypad emulator.
// The requester drives key/hold with valid; the emulator returns ready.
interface keypad_emulator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder with LFSR contact bounce.
// Sequences press/hold/release per command; cols follow key_row live.
module keypad_emulator #(
  parameter int          BOUNCE_CYCLES  = 16,
  parameter int          RELEASE_CYCLES = 32,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  keypad_emulator_if.slave  cmd,
  input  logic [3:0]        key_row,
  output logic [3:0]        cols,
  output logic              contact,
  output logic              done
);

  localparam logic [15:0] BNC = 16'(BOUNCE_CYCLES);
  localparam logic [15:0] REL = 16'(RELEASE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] hold_q;
  logic [15:0] hold_in;
  logic [3:0]  key_q;
  logic [7:0]  lfsr;
  logic        ready_q;
  logic        accept;
  logic        last;
  logic        contact_nxt;
  logic        done_nxt;
  logic [3:0]  col_sel;

  assign hold_in = (cmd.cmd_hold == 16'd0) ? 16'd1 : cmd.cmd_hold;
  assign accept  = cmd.cmd_valid & ready_q;
  assign last    = (cnt == 16'd1);
  assign cmd.cmd_ready = ready_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (BOUNCE_CYCLES == 0) begin
            state_nxt = HOLD;
            cnt_nxt   = hold_in;
          end else begin
            state_nxt = BOUNCE_IN;
            cnt_nxt   = BNC;
          end
        end
      end
      BOUNCE_IN: begin
        if (last) begin
          state_nxt = HOLD;
          cnt_nxt   = hold_q;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      HOLD: begin
        if (last) begin
          if (BOUNCE_CYCLES == 0) begin
            state_nxt = GAP;
            cnt_nxt   = REL;
          end else begin
            state_nxt = BOUNCE_OUT;
            cnt_nxt   = BNC;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      BOUNCE_OUT: begin
        if (last) begin
          state_nxt = GAP;
          cnt_nxt   = REL;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (last) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Final bounce cycle is forced so each phase settles cleanly.
  always_comb begin
    contact_nxt = 1'b0;
    unique case (state_nxt)
      BOUNCE_IN:  contact_nxt = (cnt_nxt == 16'd1) | lfsr[0];
      HOLD:       contact_nxt = 1'b1;
      BOUNCE_OUT: contact_nxt = (cnt_nxt != 16'd1) & lfsr[0];
      default:    contact_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      hold_q  <= 16'd0;
      key_q   <= 4'd0;
      lfsr    <= LFSR_SEED;
      ready_q <= 1'b0;
      contact <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ready_q <= (state == IDLE) && (state_nxt == IDLE);
      contact <= contact_nxt;
      done    <= done_nxt;
      if (accept) begin
        key_q  <= cmd.cmd_key;
        hold_q <= hold_in;
      end
    end
  end

  assign col_sel = 4'b0001 << key_q[1:0];
  assign cols    = (contact & ~key_row[key_q[3:2]]) ? ~col_sel : 4'b1111;

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad model that acts as the responder to the keypad scanner.
- It takes row drive from the scanner and returns column levels as if a physical key were pressed, including contact bounce on press and on release.
- A command handshake sequences each press. The block serves as an on-FPGA loopback source and as a bench model for scanner/debounce verification.

Parameters:
- BOUNCE_CYCLES, 16, number of clk cycles of randomized contact chatter on press and on release (0 = clean edges).
- RELEASE_CYCLES, 32, minimum clk cycles the contact stays open after release before the next command is accepted (minimum 1).
- LFSR_SEED, 8'hA5, nonzero reset value of the bounce LFSR.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  press request valid.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_key  input  4  key code: row index = cmd_key[3:2], column index = cmd_key[1:0].
- cmd_hold  input  16  clean-closed hold duration in clk cycles; 0 is treated as 1.
- key_row  input  4  row drive from the scanner, active-low; the driven row is 0.
- cols  output  4  column sense to the scanner, active-low; idle 4'b1111.
- contact  output  1  current modeled switch state (1 = closed); debug/LED.
- done  output  1  one-cycle pulse when a press/release sequence finishes.

Behaviour:
- Reset, sampled on posedge clk while reset=0:
  - state=IDLE, contact=0, done=0, cmd_ready=1 (asserted the cycle after reset is released), cols=4'b1111.
  - LFSR=LFSR_SEED; stored key and counters cleared.
  - Reset mid-sequence aborts immediately; the contact opens with no release bounce.
- cols is combinational:
  - cols[c] = 0 iff contact=1, c = stored col index, and key_row[stored row index] = 0. Otherwise cols[c] = 1.
  - Multiple rows low: a column goes low if the stored row is among them.
  - Row changes propagate to cols in the same cycle, with no latency, as a real switch would.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk cycle after reset.
- Handshake:
  - A command is accepted on the posedge where cmd_valid=1 and cmd_ready=1.
  - cmd_key and max(cmd_hold,1) are captured; the next state is BOUNCE_IN.
  - cmd_valid while cmd_ready=0 is ignored, with no queuing; the requester must hold valid.
- FSM:
  - IDLE: contact=0, cmd_ready=1. On accept → BOUNCE_IN, or → HOLD if BOUNCE_CYCLES=0.
  - BOUNCE_IN: lasts exactly BOUNCE_CYCLES cycles; contact=LFSR[0] each cycle, except the final cycle forces contact=1. Then → HOLD.
  - HOLD: contact=1 for exactly the captured hold count, then → BOUNCE_OUT, or → GAP if BOUNCE_CYCLES=0.
  - BOUNCE_OUT: lasts BOUNCE_CYCLES cycles; contact=LFSR[0], except the final cycle forces contact=0. Then → GAP.
  - GAP: contact=0 for RELEASE_CYCLES cycles. On the last cycle, done=1 for one cycle and next state is IDLE.
- Latency: cmd_ready returns exactly 2·BOUNCE_CYCLES + hold + RELEASE_CYCLES + 1 cycles after the accept edge, where hold = max(cmd_hold,1).
- Counters: 16-bit down-counters. cmd_hold=16'hFFFF gives a 65535-cycle hold with no wrap.
- Outputs contact and done are registered. cols is derived combinationally from registered contact/key and live key_row.

Test Plan:
- Reset held 3 cycles with cmd_valid=1 → cmd_ready=0 during reset, cols=4'b1111, contact=0. cmd_ready=1 the cycle after release. No command accepted while in reset.
- BOUNCE_CYCLES=0, cmd_key=4'h6, cmd_hold=10, key_row cycling 1110/1101/1011/0111 → cols=4'b1011 only while key_row=4'b1101, for exactly 10 cycles. done pulses after RELEASE_CYCLES more cycles.
- Default params, cmd_key=4'hF, cmd_hold=100 → contact toggles during 16 bounce-in cycles and ends 1. Exactly 100 clean cycles follow, then 16 bounce-out cycles ending 0. cmd_ready returns 16+100+16+32+1 cycles after accept.
- cmd_hold=0 → treated as a 1-cycle hold. Second cmd_valid asserted mid-HOLD → ignored; accepted only once IDLE is reached.
- key_row=4'b0000 (all rows driven), cmd_key=4'h0 during HOLD → cols=4'b1110. key_row=4'b1111 → cols=4'b1111 regardless of contact.
- Reset asserted mid-HOLD → contact=0 and cols=4'b1111 on the next edge, no done pulse. A fresh command is accepted normally afterwards.
